ascon_fsm_param: RTL

//  Parametrised Moore control FSM for the ASCON-128a datapath with an integrated round counter.

---
 rtl/ascon_pkg.sv | 52 +++++
 rtl/ascon_round_counter.sv | 27 ++
 rtl/ascon_fsm_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types and round constants for the ASCON-128a control FSM.
// ctrl_t bundles every datapath strobe so that output decoding is a single struct.
package ascon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD_WAIT,
        ST_AD_RUN,
        ST_PT_WAIT,
        ST_PT_RUN,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam int ROUND_W        = 4;
    localparam int ROUND_PA_FIRST = 0;
    localparam int ROUND_LAST     = 11;
    localparam int ROUNDS_B_DEF   = 8;
    localparam int ROUND_PB_FIRST = ROUND_LAST + 1 - ROUNDS_B_DEF;

    typedef struct packed {
        logic ready;
        logic busy;
        logic end_init;
        logic end_assoc;
        logic end_block;
        logic end_done;
        logic cipher_valid;
        logic en_reg_cipher;
        logic en_reg_tag;
        logic input_mode;
        logic en_reg_state;
        logic en_xor_begin_data;
        logic en_xor_begin_key;
        logic bypass_xor_end;
        logic mode_xor_key;
    } ctrl_t;

    // Quiescent strobe set: only the end-XOR bypass is active.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        c.bypass_xor_end = 1'b1;
        return c;
    endfunction

    function automatic logic [ROUND_W-1:0] pb_first(input int rounds_b);
        return ROUND_W'(ROUND_LAST + 1 - rounds_b);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round index register: loadable start value, saturating increment at ROUND_LAST.
// last_round flags the final pb round; pa end is decoded by the caller.
module ascon_round_counter
    import ascon_pkg::*;
(
    input  logic               clock_s,
    input  logic               reset_s,
    input  logic               load,
    input  logic [ROUND_W-1:0] load_val,
    input  logic               en,
    output logic [ROUND_W-1:0] round,
    output logic               last_round
);

    always_ff @(posedge clock_s or posedge reset_s) begin
        if (reset_s) begin
            round <= '0;
        end else if (load) begin
            round <= load_val;
        end else if (en && (round < ROUND_W'(ROUND_LAST))) begin
            round <= round + ROUND_W'(1);
        end
    end

    assign last_round = (round == ROUND_W'(ROUND_LAST));

endmodule

// File: rtl/ascon_fsm_param.sv
// ASCON-128a Moore control FSM: INIT(pa) -> AD blocks(pb) -> PT blocks(pb) -> FINAL(pa) -> DONE.
// Data accepted only in *_WAIT via data_valid_i/ready_o; ASCON_ABORT_EN adds abort_i/aborted_o.
module ascon_fsm_param
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A  = 12,
    parameter int ROUNDS_B  = ROUNDS_B_DEF,
    parameter int NB_AD_MAX = 4,
    parameter int NB_PT_MAX = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
`ifdef ASCON_ABORT_EN
    input  logic                           abort_i,
    output logic                           aborted_o,
`endif
    input  logic                           start_i,
    input  logic [$clog2(NB_AD_MAX+1)-1:0] nb_ad_i,
    input  logic [$clog2(NB_PT_MAX+1)-1:0] nb_pt_i,
    input  logic                           data_valid_i,
    output logic [3:0]                     round_o,
    output logic                           ready_o,
    output logic                           busy_o,
    output logic                           end_initialisation_o,
    output logic                           end_associate_o,
    output logic                           end_block_o,
    output logic                           end_o,
    output logic                           cipher_valid_o,
    output logic                           en_reg_cipher_o,
    output logic                           en_reg_tag_o,
    output logic                           input_mode_o,
    output logic                           en_reg_state_o,
    output logic                           en_xor_begin_data_o,
    output logic                           en_xor_begin_key_o,
    output logic                           bypass_xor_end_o,
    output logic                           mode_xor_key_o
);

    localparam int AD_W = $clog2(NB_AD_MAX+1);
    localparam int PT_W = $clog2(NB_PT_MAX+1);
    localparam logic [ROUND_W-1:0] PA_FIRST = ROUND_W'(ROUND_PA_FIRST);
    localparam logic [ROUND_W-1:0] PA_LAST  = ROUND_W'(ROUNDS_A - 1);
    localparam logic [ROUND_W-1:0] PB_FIRST = pb_first(ROUNDS_B);

    state_t            state_q, state_d;
    logic [AD_W-1:0]   nb_ad_q, nb_ad_d, ad_cnt_q, ad_cnt_d;
    logic [PT_W-1:0]   nb_pt_q, nb_pt_d, pt_cnt_q, pt_cnt_d;
    logic              first_q, first_d;
    logic              blk_done_q, blk_done_d;
    logic              rnd_load, rnd_en, pb_last, pa_last, last_ad, last_pt, abort;
    logic [ROUND_W-1:0] rnd_load_val, round;
    ctrl_t             ctrl;

    ascon_round_counter u_round (
        .clock_s    (clock_i),
        .reset_s    (reset_i),
        .load       (rnd_load),
        .load_val   (rnd_load_val),
        .en         (rnd_en),
        .round      (round),
        .last_round (pb_last)
    );

    assign pa_last = (round == PA_LAST);
    assign last_ad = ((ad_cnt_q + AD_W'(1)) == nb_ad_q);
    assign last_pt = ((pt_cnt_q + PT_W'(1)) == nb_pt_q);

`ifdef ASCON_ABORT_EN
    assign abort = abort_i && (state_q != ST_IDLE);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            nb_ad_q    <= '0;
            nb_pt_q    <= '0;
            ad_cnt_q   <= '0;
            pt_cnt_q   <= '0;
            first_q    <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nb_ad_q    <= nb_ad_d;
            nb_pt_q    <= nb_pt_d;
            ad_cnt_q   <= ad_cnt_d;
            pt_cnt_q   <= pt_cnt_d;
            first_q    <= first_d;
            blk_done_q <= blk_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        nb_ad_d      = nb_ad_q;
        nb_pt_d      = nb_pt_q;
        ad_cnt_d     = ad_cnt_q;
        pt_cnt_d     = pt_cnt_q;
        first_d      = 1'b0;
        blk_done_d   = 1'b0;
        rnd_load     = 1'b0;
        rnd_load_val = PA_FIRST;
        rnd_en       = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d  = ST_INIT;
                nb_ad_d  = (nb_ad_i > AD_W'(NB_AD_MAX)) ? AD_W'(NB_AD_MAX) : nb_ad_i;
                nb_pt_d  = (nb_pt_i == '0) ? PT_W'(1) :
                           (nb_pt_i > PT_W'(NB_PT_MAX)) ? PT_W'(NB_PT_MAX) : nb_pt_i;
                ad_cnt_d = '0;
                pt_cnt_d = '0;
                rnd_load = 1'b1;
            end
            ST_INIT: begin
                rnd_en = 1'b1;
                if (pa_last) state_d = (nb_ad_q == '0) ? ST_PT_WAIT : ST_AD_WAIT;
            end
            ST_AD_WAIT: if (data_valid_i) begin
                state_d      = ST_AD_RUN;
                rnd_load     = 1'b1;
                rnd_load_val = PB_FIRST;
            end
            ST_AD_RUN: begin
                rnd_en = 1'b1;
                if (pb_last) begin
                    if (ad_cnt_q < nb_ad_q) ad_cnt_d = ad_cnt_q + AD_W'(1);
                    state_d = last_ad ? ST_PT_WAIT : ST_AD_WAIT;
                end
            end
            ST_PT_WAIT: if (data_valid_i) begin
                first_d      = 1'b1;
                rnd_load     = 1'b1;
                state_d      = last_pt ? ST_FINAL : ST_PT_RUN;
                rnd_load_val = last_pt ? PA_FIRST : PB_FIRST;
            end
            // First cycle of PT_RUN/FINAL absorbs data; the round counter holds until it ends.
            ST_PT_RUN: if (!first_q) begin
                rnd_en = 1'b1;
                if (pb_last) begin
                    if (pt_cnt_q < nb_pt_q) pt_cnt_d = pt_cnt_q + PT_W'(1);
                    blk_done_d = 1'b1;
                    state_d    = ST_PT_WAIT;
                end
            end
            ST_FINAL: if (!first_q) begin
                rnd_en = 1'b1;
                if (pa_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rnd_load = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d      = ST_IDLE;
            rnd_load     = 1'b1;
            rnd_load_val = PA_FIRST;
        end
    end

    always_comb begin
        ctrl = ctrl_idle();
        case (state_q)
            ST_INIT: begin
                ctrl.busy         = 1'b1;
                ctrl.en_reg_state = 1'b1;
                ctrl.input_mode   = (round != PA_FIRST);
                if (pa_last) begin
                    ctrl.bypass_xor_end = 1'b0;
                    ctrl.mode_xor_key   = 1'b1;
                end
            end
            ST_AD_WAIT: begin
                ctrl.busy     = 1'b1;
                ctrl.ready    = 1'b1;
                ctrl.end_init = 1'b1;
            end
            ST_AD_RUN: begin
                ctrl.busy              = 1'b1;
                ctrl.en_reg_state      = 1'b1;
                ctrl.input_mode        = 1'b1;
                ctrl.en_xor_begin_data = (round == PB_FIRST);
                if (pb_last && last_ad) ctrl.bypass_xor_end = 1'b0;
            end
            ST_PT_WAIT: begin
                ctrl.busy      = 1'b1;
                ctrl.ready     = 1'b1;
                ctrl.end_init  = (nb_ad_q == '0);
                ctrl.end_assoc = (nb_ad_q != '0);
                ctrl.end_block = blk_done_q;
            end
            ST_PT_RUN: begin
                ctrl.busy              = 1'b1;
                ctrl.en_reg_state      = 1'b1;
                ctrl.input_mode        = 1'b1;
                ctrl.en_xor_begin_data = first_q;
                ctrl.cipher_valid      = first_q;
                ctrl.en_reg_cipher     = first_q;
            end
            ST_FINAL: begin
                ctrl.busy              = 1'b1;
                ctrl.en_reg_state      = 1'b1;
                ctrl.input_mode        = 1'b1;
                ctrl.en_xor_begin_data = first_q;
                ctrl.en_xor_begin_key  = first_q;
                ctrl.cipher_valid      = first_q;
                if (!first_q && pa_last) begin
                    ctrl.bypass_xor_end = 1'b0;
                    ctrl.mode_xor_key   = 1'b1;
                    ctrl.en_reg_tag     = 1'b1;
                end
            end
            ST_DONE: begin
                ctrl.busy     = 1'b1;
                ctrl.end_done = 1'b1;
            end
            default: ctrl = ctrl_idle();
        endcase
    end

`ifdef ASCON_ABORT_EN
    assign aborted_o = abort;
`endif
    assign en_reg_tag_o         = ctrl.en_reg_tag & ~abort;
    assign en_reg_cipher_o      = ctrl.en_reg_cipher & ~abort;
    assign round_o              = round;
    assign ready_o              = ctrl.ready;
    assign busy_o               = ctrl.busy;
    assign end_initialisation_o = ctrl.end_init;
    assign end_associate_o      = ctrl.end_assoc;
    assign end_block_o          = ctrl.end_block;
    assign end_o                = ctrl.end_done;
    assign cipher_valid_o       = ctrl.cipher_valid;
    assign input_mode_o         = ctrl.input_mode;
    assign en_reg_state_o       = ctrl.en_reg_state;
    assign en_xor_begin_data_o  = ctrl.en_xor_begin_data;
    assign en_xor_begin_key_o   = ctrl.en_xor_begin_key;
    assign bypass_xor_end_o     = ctrl.bypass_xor_end;
    assign mode_xor_key_o       = ctrl.mode_xor_key;

endmodule
